// File: rtl/wb_io_pkg.sv
// Shared definitions for the Wishbone I/O arbiter slice.
//   arb_state_e : arbiter FSM states
//   M0 / M1     : master indices (CPU data port / debug-DMA port)
//   WB_DW/WB_AW : Wishbone data and address widths
package wb_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_e;

    localparam int M0    = 0;
    localparam int M1    = 1;
    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Outstanding-strobe tracker and ack-timeout watchdog for the I/O arbiter.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_accept              : a strobe was accepted by the peripheral this cycle
//   i_ack                 : raw ack from the peripheral (already gated by grant)
//   i_clear               : drop all tracking (release, abort, no grant)
//   o_ack_valid           : ack that matches an outstanding or same-cycle strobe
//   o_outstanding_zero    : nothing outstanding
//   o_outstanding_full    : counter saturated and no ack draining it this cycle
//   o_timeout             : watchdog expired with no ack this cycle
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OUTST_W        = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_accept,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_ack_valid,
    output logic o_outstanding_zero,
    output logic o_outstanding_full,
    output logic o_timeout
);

    localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OUTST_W-1:0] OUTST_MAX = {OUTST_W{1'b1}};
    localparam logic [WD_W-1:0]    WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);

    logic [OUTST_W-1:0] outst_q, outst_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    assign o_outstanding_zero = (outst_q == '0);

    // A slave that acks combinationally answers the strobe it is accepting
    // right now, so an ack is legal either with something outstanding or
    // alongside a same-cycle accept. Any other ack is a stray and is dropped.
    assign o_ack_valid = i_ack & (!o_outstanding_zero | i_accept);

    // An ack at saturation frees a slot in the same cycle. Only the raw ack is
    // used here: at saturation the count is non-zero so every ack is valid,
    // and it keeps full -> stb -> accept -> ack_valid free of a loop.
    assign o_outstanding_full = (outst_q == OUTST_MAX) & !i_ack;

    // An ack arriving on the expiry cycle wins; err and ack never coincide.
    assign o_timeout = (wdog_q == WD_LIMIT) & !o_ack_valid;

    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        outst_d = outst_q;
        wdog_d  = wdog_q;

        if (i_clear) begin
            outst_d = '0;
        end else begin
            case ({i_accept, o_ack_valid})
                2'b10:   outst_d = outst_q + OUTST_W'(1);
                2'b01:   outst_d = outst_q - OUTST_W'(1);
                default: outst_d = outst_q;
            endcase
        end

        // Watchdog measures silence: any bus progress restarts it.
        if (i_clear || i_accept || o_ack_valid || o_outstanding_zero) begin
            wdog_d = '0;
        end else if (wdog_q != WD_LIMIT) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            outst_q <= '0;
            wdog_q  <= '0;
        end else begin
            outst_q <= outst_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: rtl/wb_io_arbiter.sv
// Round-robin arbiter letting two pipelined Wishbone masters share one I/O
// peripheral bus. Master 0 is the CPU data port, master 1 the debug/DMA port.
// A watchdog turns a silent peripheral into a one-cycle err to the granted
// master followed by a one-cycle bus abort.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_mN_wb_*  (N = 0, 1)       : master N request (cycle, stb, we, addr, data)
//   o_mN_wb_*                   : master N response (stall, ack, err, data)
//   o_wb_*                      : request to the peripheral bus
//   i_wb_stall/ack/data         : response from the peripheral bus
module wb_io_arbiter
    import wb_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OUTST_W        = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,

    input  logic             i_m0_wb_cycle,
    input  logic             i_m0_wb_stb,
    input  logic             i_m0_wb_we,
    input  logic [WB_AW-1:0] i_m0_wb_addr,
    input  logic [WB_DW-1:0] i_m0_wb_data,
    output logic             o_m0_wb_stall,
    output logic             o_m0_wb_ack,
    output logic             o_m0_wb_err,
    output logic [WB_DW-1:0] o_m0_wb_data,

    input  logic             i_m1_wb_cycle,
    input  logic             i_m1_wb_stb,
    input  logic             i_m1_wb_we,
    input  logic [WB_AW-1:0] i_m1_wb_addr,
    input  logic [WB_DW-1:0] i_m1_wb_data,
    output logic             o_m1_wb_stall,
    output logic             o_m1_wb_ack,
    output logic             o_m1_wb_err,
    output logic [WB_DW-1:0] o_m1_wb_data,

    output logic             o_wb_cycle,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [WB_AW-1:0] o_wb_addr,
    output logic [WB_DW-1:0] o_wb_data,
    input  logic             i_wb_stall,
    input  logic             i_wb_ack,
    input  logic [WB_DW-1:0] i_wb_data
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic             gnt0, gnt1, granted;
    logic             sel_cycle, sel_stb, sel_we;
    logic [WB_AW-1:0] sel_addr;
    logic [WB_DW-1:0] sel_data;
    logic             accept, ack_raw, ack_valid, release_cyc, clear;
    logic             outst_zero, outst_full, timeout;

    assign gnt0    = (state_q == GRANT0);
    assign gnt1    = (state_q == GRANT1);
    assign granted = gnt0 | gnt1;

    // Request mux from the granted master (master 0 when idle; gated below).
    assign sel_cycle = gnt1 ? i_m1_wb_cycle : i_m0_wb_cycle;
    assign sel_stb   = gnt1 ? i_m1_wb_stb   : i_m0_wb_stb;
    assign sel_we    = gnt1 ? i_m1_wb_we    : i_m0_wb_we;
    assign sel_addr  = gnt1 ? i_m1_wb_addr  : i_m0_wb_addr;
    assign sel_data  = gnt1 ? i_m1_wb_data  : i_m0_wb_data;

    assign o_wb_cycle = granted;
    assign o_wb_stb   = granted & sel_cycle & sel_stb & !outst_full;
    assign o_wb_we    = granted & sel_we;
    assign o_wb_addr  = granted ? sel_addr : '0;
    assign o_wb_data  = granted ? sel_data : '0;

    assign accept      = o_wb_stb & !i_wb_stall;
    assign ack_raw     = granted & i_wb_ack;
    assign release_cyc = granted & !sel_cycle;
    assign clear       = !granted | release_cyc | timeout;

    assign o_m0_wb_stall = !gnt0 | i_wb_stall | outst_full;
    assign o_m0_wb_ack   = gnt0 & ack_valid;
    assign o_m0_wb_err   = gnt0 & timeout;
    assign o_m0_wb_data  = gnt0 ? i_wb_data : '0;

    assign o_m1_wb_stall = !gnt1 | i_wb_stall | outst_full;
    assign o_m1_wb_ack   = gnt1 & ack_valid;
    assign o_m1_wb_err   = gnt1 & timeout;
    assign o_m1_wb_data  = gnt1 ? i_wb_data : '0;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .OUTST_W        (OUTST_W)
    ) u_watchdog (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_accept           (accept),
        .i_ack              (ack_raw),
        .i_clear            (clear),
        .o_ack_valid        (ack_valid),
        .o_outstanding_zero (outst_zero),
        .o_outstanding_full (outst_full),
        .o_timeout          (timeout)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                // On contention the master that did not hold the bus last wins.
                if (i_m0_wb_cycle && (!i_m1_wb_cycle || last_grant_q == 1'(M1))) begin
                    state_d = GRANT0;
                end else if (i_m1_wb_cycle) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (timeout) begin
                    state_d      = ABORT;
                    last_grant_d = 1'(M0);
                end else if (!i_m0_wb_cycle) begin
                    state_d      = i_m1_wb_cycle ? GRANT1 : IDLE;
                    last_grant_d = 1'(M0);
                end
            end
            GRANT1: begin
                if (timeout) begin
                    state_d      = ABORT;
                    last_grant_d = 1'(M1);
                end else if (!i_m1_wb_cycle) begin
                    state_d      = i_m0_wb_cycle ? GRANT0 : IDLE;
                    last_grant_d = 1'(M1);
                end
            end
            default: begin
                // ABORT: one cycle with the bus dropped, then re-arbitrate.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'(M1);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Self-checking bench for wb_io_arbiter. Directed stimulus pushes expected
// forwarded strobes and master responses into queues; a negedge monitor pops
// and compares whenever the DUT forwards a strobe or answers a master.
module tb_wb_io_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_m0_wb_cycle, i_m0_wb_stb, i_m0_wb_we;
    logic [31:0] i_m0_wb_addr, i_m0_wb_data;
    logic        o_m0_wb_stall, o_m0_wb_ack, o_m0_wb_err;
    logic [31:0] o_m0_wb_data;
    logic        i_m1_wb_cycle, i_m1_wb_stb, i_m1_wb_we;
    logic [31:0] i_m1_wb_addr, i_m1_wb_data;
    logic        o_m1_wb_stall, o_m1_wb_ack, o_m1_wb_err;
    logic [31:0] o_m1_wb_data;
    logic        o_wb_cycle, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic        i_wb_stall, i_wb_ack;
    logic [31:0] i_wb_data;

    // Slave model: manual ack, or an LED-like register that acks any
    // accepted strobe in the same cycle.
    logic led_mode, man_ack;
    assign i_wb_ack = man_ack | (led_mode & o_wb_stb & ~i_wb_stall);

    always #5 i_clk = ~i_clk;

    wb_io_arbiter #(.TIMEOUT_CYCLES(8), .OUTST_W(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_wb_cycle(i_m0_wb_cycle), .i_m0_wb_stb(i_m0_wb_stb), .i_m0_wb_we(i_m0_wb_we),
        .i_m0_wb_addr(i_m0_wb_addr), .i_m0_wb_data(i_m0_wb_data),
        .o_m0_wb_stall(o_m0_wb_stall), .o_m0_wb_ack(o_m0_wb_ack), .o_m0_wb_err(o_m0_wb_err),
        .o_m0_wb_data(o_m0_wb_data),
        .i_m1_wb_cycle(i_m1_wb_cycle), .i_m1_wb_stb(i_m1_wb_stb), .i_m1_wb_we(i_m1_wb_we),
        .i_m1_wb_addr(i_m1_wb_addr), .i_m1_wb_data(i_m1_wb_data),
        .o_m1_wb_stall(o_m1_wb_stall), .o_m1_wb_ack(o_m1_wb_ack), .o_m1_wb_err(o_m1_wb_err),
        .o_m1_wb_data(o_m1_wb_data),
        .o_wb_cycle(o_wb_cycle), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } fwd_t;

    typedef struct packed {
        logic        m;
        logic        is_err;
        logic [31:0] data;
    } resp_t;

    fwd_t  fwd_q[$];
    resp_t resp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic exp_fwd(input logic we, input logic [31:0] addr, input logic [31:0] data);
        fwd_q.push_back('{we: we, addr: addr, data: data});
    endtask

    task automatic exp_resp(input logic m, input logic is_err, input logic [31:0] data);
        resp_q.push_back('{m: m, is_err: is_err, data: data});
    endtask

    // Bus dropped, nothing forwarded, both masters stalled and silent.
    task automatic check_quiet(input string tag);
        check({tag, "_cycle"}, 32'(o_wb_cycle), 32'd0);
        check({tag, "_stb"}, 32'(o_wb_stb), 32'd0);
        check({tag, "_we"}, 32'(o_wb_we), 32'd0);
        check({tag, "_addr"}, o_wb_addr, 32'd0);
        check({tag, "_wdata"}, o_wb_data, 32'd0);
        check({tag, "_stall0"}, 32'(o_m0_wb_stall), 32'd1);
        check({tag, "_stall1"}, 32'(o_m1_wb_stall), 32'd1);
        check({tag, "_ackerr"}, 32'({o_m0_wb_ack, o_m0_wb_err, o_m1_wb_ack, o_m1_wb_err}), 32'd0);
        check({tag, "_rdata"}, o_m0_wb_data | o_m1_wb_data, 32'd0);
    endtask

    // Monitor: every forwarded strobe and every master response must match
    // the head of its expectation queue.
    fwd_t  mon_f;
    resp_t mon_r;
    always @(negedge i_clk) begin
        if (o_wb_stb && !i_wb_stall) begin
            if (fwd_q.size() == 0) begin
                check("unexpected_fwd", o_wb_addr, 32'hFFFF_FFFF);
            end else begin
                mon_f = fwd_q.pop_front();
                check("fwd_we", 32'(o_wb_we), 32'(mon_f.we));
                check("fwd_addr", o_wb_addr, mon_f.addr);
                check("fwd_data", o_wb_data, mon_f.data);
            end
        end
        for (int m = 0; m < 2; m++) begin
            logic        a, e;
            logic [31:0] d;
            a = (m == 1) ? o_m1_wb_ack  : o_m0_wb_ack;
            e = (m == 1) ? o_m1_wb_err  : o_m0_wb_err;
            d = (m == 1) ? o_m1_wb_data : o_m0_wb_data;
            if (a && e) check("ack_err_exclusive", 32'(m), 32'hFFFF_FFFF);
            if (a || e) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", 32'({m[0], e}), 32'hFFFF_FFFF);
                end else begin
                    mon_r = resp_q.pop_front();
                    check("resp_master", 32'(m), 32'(mon_r.m));
                    check("resp_is_err", 32'(e), 32'(mon_r.is_err));
                    if (!mon_r.is_err) check("resp_data", d, mon_r.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        i_reset = 1'b1;
        {i_m0_wb_cycle, i_m0_wb_stb, i_m0_wb_we} = '0;
        {i_m1_wb_cycle, i_m1_wb_stb, i_m1_wb_we} = '0;
        i_m0_wb_addr = '0; i_m0_wb_data = '0;
        i_m1_wb_addr = '0; i_m1_wb_data = '0;
        i_wb_stall = 1'b0; i_wb_data = '0;
        led_mode = 1'b0; man_ack = 1'b0;
        step(); step();
        #1 check_quiet("reset");
        step();
        i_reset = 1'b0;

        // ---- Arbitration: m0 first after reset, hand-over, round robin ----
        i_m0_wb_cycle = 1; i_m1_wb_cycle = 1;
        #1 check("arb_idle_cycle", 32'(o_wb_cycle), 32'd0);
        step();
        led_mode = 1; i_wb_data = 32'h0000_00C1;
        i_m0_wb_stb = 1; i_m0_wb_we = 1; i_m0_wb_addr = 32'h4; i_m0_wb_data = 32'h11;
        exp_fwd(1'b1, 32'h4, 32'h11);
        exp_resp(1'b0, 1'b0, 32'h0000_00C1);
        #1 check("arb_m0_first_stall0", 32'(o_m0_wb_stall), 32'd0);
        check("arb_m0_first_stall1", 32'(o_m1_wb_stall), 32'd1);
        check("arb_m1_data_zero", o_m1_wb_data, 32'd0);
        step();
        i_m0_wb_stb = 0; i_m0_wb_cycle = 0;
        #1 check("arb_release_cycle_hold", 32'(o_wb_cycle), 32'd1);
        check("arb_release_stall1", 32'(o_m1_wb_stall), 32'd1);
        step();
        i_m1_wb_stb = 1; i_m1_wb_we = 1; i_m1_wb_addr = 32'h20; i_m1_wb_data = 32'h1;
        i_wb_data = 32'h0000_00C2;
        exp_fwd(1'b1, 32'h20, 32'h1);
        exp_resp(1'b1, 1'b0, 32'h0000_00C2);
        #1 check("arb_handover_stall1", 32'(o_m1_wb_stall), 32'd0);
        check("arb_handover_stall0", 32'(o_m0_wb_stall), 32'd1);
        step();
        i_m1_wb_stb = 0; i_m1_wb_cycle = 0;
        step();
        i_m0_wb_cycle = 1; i_m1_wb_cycle = 1;
        #1 check("arb_idle_again", 32'(o_wb_cycle), 32'd0);
        step();
        #1 check("arb_rr_stall0", 32'(o_m0_wb_stall), 32'd0);
        check("arb_rr_stall1", 32'(o_m1_wb_stall), 32'd1);
        i_m0_wb_cycle = 0; i_m1_wb_cycle = 0;
        step(); step();

        // ---- LED write acked same cycle, stray acks dropped ----
        i_m0_wb_cycle = 1; i_m0_wb_stb = 1; i_m0_wb_we = 1;
        i_m0_wb_addr = 32'h10; i_m0_wb_data = 32'h0000_A5A5; i_wb_data = 32'h0000_5A5A;
        exp_fwd(1'b1, 32'h10, 32'h0000_A5A5);
        exp_resp(1'b0, 1'b0, 32'h0000_5A5A);
        #1 check("led_idle_no_stb", 32'(o_wb_stb), 32'd0);
        step();
        #1 check("led_fwd_stb", 32'(o_wb_stb), 32'd1);
        check("led_ack_same_cycle", 32'(o_m0_wb_ack), 32'd1);
        step();
        i_m0_wb_stb = 0; man_ack = 1;
        #1 check("stray_ack_m0", 32'(o_m0_wb_ack), 32'd0);
        check("stray_ack_m1", 32'(o_m1_wb_ack), 32'd0);
        step();
        man_ack = 0; led_mode = 0;
        i_m0_wb_stb = 1; i_m0_wb_we = 0; i_m0_wb_addr = 32'h14; i_m0_wb_data = 32'h0;
        exp_fwd(1'b0, 32'h14, 32'h0);
        #1 check("stray_no_wrap_stall", 32'(o_m0_wb_stall), 32'd0);
        step();
        i_m0_wb_stb = 0; man_ack = 1; i_wb_data = 32'h1234_5678;
        exp_resp(1'b0, 1'b0, 32'h1234_5678);
        step();
        #1 check("second_ack_dropped", 32'(o_m0_wb_ack), 32'd0);
        step();
        man_ack = 0; i_m0_wb_cycle = 0;
        #1 check("drop_cycle_lag", 32'(o_wb_cycle), 32'd1);
        step();
        #1 check("drop_cycle_idle", 32'(o_wb_cycle), 32'd0);

        // ---- Saturation: 15 outstanding, 16th stalls, ack frees a slot ----
        i_m1_wb_cycle = 1; i_m1_wb_we = 1;
        step();
        for (int i = 0; i < 15; i++) begin
            i_m1_wb_stb = 1; i_m1_wb_addr = 32'h100 + 32'(4 * i); i_m1_wb_data = 32'(i);
            exp_fwd(1'b1, i_m1_wb_addr, i_m1_wb_data);
            #1 check("sat_fill_stall", 32'(o_m1_wb_stall), 32'd0);
            step();
        end
        i_m1_wb_addr = 32'h200; i_m1_wb_data = 32'hF;
        #1 check("sat_full_stall", 32'(o_m1_wb_stall), 32'd1);
        check("sat_full_stb", 32'(o_wb_stb), 32'd0);
        step();
        man_ack = 1; i_wb_data = 32'h0000_BEEF;
        exp_resp(1'b1, 1'b0, 32'h0000_BEEF);
        exp_fwd(1'b1, 32'h200, 32'hF);
        #1 check("sat_ack_unstall", 32'(o_m1_wb_stall), 32'd0);
        check("sat_ack_stb", 32'(o_wb_stb), 32'd1);
        step();
        man_ack = 0; i_m1_wb_stb = 0;
        #1 check("sat_still_full", 32'(o_m1_wb_stall), 32'd1);
        step();
        i_m1_wb_cycle = 0;
        step();
        man_ack = 1;
        #1 check("sat_late_ack", 32'(o_m1_wb_ack), 32'd0);
        step();
        man_ack = 0;

        // ---- Reset while GRANT1 holds 3 outstanding ----
        i_m1_wb_cycle = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            i_m1_wb_stb = 1; i_m1_wb_addr = 32'h300 + 32'(i); i_m1_wb_data = 32'h30 + 32'(i);
            exp_fwd(1'b1, i_m1_wb_addr, i_m1_wb_data);
            step();
        end
        i_m1_wb_stb = 0; i_reset = 1;
        step();
        i_reset = 0; i_m1_wb_cycle = 0; man_ack = 1;
        #1 check_quiet("rst_mid");
        step();
        man_ack = 0;

        // ---- Watchdog timeout on a silent slave ----
        i_m0_wb_cycle = 1;
        step();
        i_m0_wb_stb = 1; i_m0_wb_we = 0; i_m0_wb_addr = 32'h40; i_m0_wb_data = 32'h0;
        exp_fwd(1'b0, 32'h40, 32'h0);
        exp_resp(1'b0, 1'b1, 32'h0);
        step();
        i_m0_wb_stb = 0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (o_m0_wb_err) begin
                k = i;
                break;
            end
            step();
        end
        check("timeout_cycle", 32'(k), 32'd9);
        step();
        i_m0_wb_cycle = 0;
        #1 check_quiet("abort");
        step();
        i_m0_wb_cycle = 1; i_m1_wb_cycle = 1;
        #1 check("post_abort_idle", 32'(o_wb_cycle), 32'd0);
        step();
        #1 check("post_abort_m1_wins", 32'(o_m1_wb_stall), 32'd0);
        check("post_abort_m0_stalled", 32'(o_m0_wb_stall), 32'd1);
        i_m0_wb_cycle = 0; i_m1_wb_cycle = 0;
        step(); step();

        check("fwd_queue_drained", 32'(fwd_q.size()), 32'd0);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
